jump_ctrl: RTL and testbench
============================

// Module: jump_ctrl
// PURPOSE
//  Vertical-motion sequencer for the player sprite; sits directly upstream of the free-fall step stage.
//  Holds the authoritative height/velocity, drives the step stage's initial position/velocity once per
//  frame tick and captures its result. Also handles jump requests, walk-off drops, platform/floor landing
//  and ceiling clamp.
//  Height is "up-positive", 0 = floor.
// PARAMETERS
//  JUMP_V   9'd40   launch velocity loaded on jump (two's complement, up-positive)
//  Y_MAX    9'd240  ceiling height; results above are clamped
//  FF_LAT   1       cycles from driving ff_y_init/ff_v_init to valid ff_y/ff_v (1..3)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  frame_tick     in   1  one-cycle pulse, one physics step per tick
//  jump_btn       in   1  raw jump button level (synchronous to clk)
//  drop_req       in   1  pulse: support vanished under sprite (walked off ledge)
//  plat_valid     in   1  a platform lies under the sprite column
//  plat_y         in   9  platform top height (unsigned, 0..Y_MAX)
//  ff_y           in   9  step-stage result height (bit 8 set = below floor)
//  ff_v           in   9  step-stage result velocity (two's complement)
//  ff_y_init      out  9  height presented to step stage
//  ff_v_init      out  9  velocity presented to step stage
//  y_pos          out  9  current height (unsigned, 0..Y_MAX)
//  v_cur          out  9  current velocity (two's complement)
//  airborne       out  1  1 while in air states
//  landed         out  1  one-cycle pulse on touchdown
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; state GROUND; jump latch and edge register cleared.
//  Jump request: rising edge of jump_btn sets jump_pend. jump_pend clears on launch or when airborne.
//  States:
//  - GROUND:
//    - on frame_tick with jump_pend: v_cur<=JUMP_V, go ISSUE.
//    - on frame_tick with drop_req seen since the last tick: v_cur<=0, go ISSUE.
//    - otherwise hold.
//  - AIR: wait for frame_tick, then go ISSUE. A frame_tick arriving in ISSUE or WAIT is dropped (no queueing).
//  - ISSUE: ff_y_init<=y_pos, ff_v_init<=v_cur (registered); load lat_cnt=FF_LAT; go WAIT.
//  - WAIT: decrement lat_cnt; at 0, capture ff_y/ff_v, go AIR, GROUND or AIR per the rules below.
//  Capture rules, in priority order:
//  - Floor: ff_y[8]=1, or (ff_y=0 and ff_v[8]=1) -> y_pos<=0, v_cur<=0, landed=1, go GROUND.
//  - Platform: plat_valid and ff_v[8]=1 and y_pos>=plat_y and ff_y<=plat_y -> y_pos<=plat_y,
//    v_cur<=0, landed=1, go GROUND.
//  - Ceiling: ff_y>Y_MAX -> y_pos<=Y_MAX, v_cur<=0, go AIR.
//  - Otherwise: y_pos<=ff_y, v_cur<=ff_v, go AIR.
//  Arithmetic: only unsigned 9-bit compares on heights; velocity sign is bit 8; no internal add/sub.
//  airborne=1 in ISSUE/WAIT/AIR. landed is registered and lasts exactly 1 cycle.
//  Simultaneous events: jump_pend and drop_req on the same tick -> jump wins.
//  A jump edge while airborne is ignored (no buffering into the next landing).
//  Reset mid-step: the in-flight result is discarded; the step stage's stale outputs are never captured
//  until the next ISSUE.
//  Step ordering: each step issues exactly once per tick; latency ISSUE->capture = FF_LAT+1 cycles.
// STRUCTURE
//  Shared package phys_pkg:
//  - state enum {GROUND, AIR, ISSUE, WAIT}
//  - G_STEP=14, JUMP_V, Y_MAX, FF_LAT
//  - 9-bit height/velocity typedefs
//  Optional sub-module: btn_edge (2-flop rising-edge detector + pending latch).
//  FSM and capture logic stay in this module.
//  Top level instantiates jump_ctrl feeding the existing free-fall step stage.
// TESTING
//  T1 Reset:
//     - rst_n low mid-WAIT -> all outputs 0, state GROUND at once.
//     - After release, no capture until a new jump.
//  T2 Jump arc (FF_LAT=1, floor only, step stage y'=y+v-7, v'=v-14):
//     - Stimulus: jump edge, then ticks.
//     - ff_v_init=40 on first issue.
//     - Captured (y,v) = (33,26) (52,12) (57,-2) (48,-16) (25,-30).
//     - 6th capture: ff_y=-12 -> y_pos=0, v_cur=0, landed pulse, GROUND.
//  T3 Platform landing:
//     - Setup: plat_valid=1, plat_y=50, replay T2.
//     - Falling capture ff_y=48 from y_pos=57 -> y_pos=50, v_cur=0, landed=1.
//  T4 Ceiling:
//     - Setup: JUMP_V=9'd250, Y_MAX=240.
//     - First capture ff_y=243 -> y_pos=240, v_cur=0, airborne stays 1.
//  T5 Drop and collisions:
//     - Drop: from y_pos=50 on platform, drop_req then tick -> ff_v_init=0.
//     - Drop continued: next capture y=43, v=-14.
//     - Jump+drop on the same tick -> ff_v_init=JUMP_V.
//  T6 Tick during WAIT (FF_LAT=3):
//     - Extra frame_tick while waiting -> ignored; exactly one capture per issue.
//     - Jump edge while airborne -> no relaunch after landing.

Source files
------------

// File: rtl/phys_pkg.sv
// ============================================================================
// Module  : phys_pkg
// Purpose : Shared state encoding, physics constants and height/velocity types.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package phys_pkg;

    typedef logic [8:0] height_t;
    typedef logic [8:0] vel_t;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        ISSUE  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam int unsigned G_STEP = 14;
    localparam vel_t        JUMP_V = 9'd40;
    localparam height_t     Y_MAX  = 9'd240;
    localparam int unsigned FF_LAT = 1;

endpackage

`default_nettype wire

// File: rtl/jump_ctrl_btn_edge.sv
// ============================================================================
// Module  : btn_edge
// Purpose : Two-flop rising-edge detector on the jump button feeding a pending latch.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic clr_i,
    output logic pend_o
);

    logic b1_q;
    logic b2_q;
    logic pend_q;
    logic pend_d;
    logic w_rise;

    assign w_rise = b1_q & ~b2_q;

    // Clear dominates so an edge seen while airborne never survives to the landing.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end else if (w_rise) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            b1_q   <= btn_i;
            b2_q   <= b1_q;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/jump_ctrl.sv
// ============================================================================
// Module  : jump_ctrl
// Purpose : Vertical-motion sequencer: issues one free-fall step per frame tick
//           and applies floor / platform / ceiling rules to the captured result.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module jump_ctrl #(
    parameter logic [8:0]  JUMP_V = phys_pkg::JUMP_V,
    parameter logic [8:0]  Y_MAX  = phys_pkg::Y_MAX,
    parameter int unsigned FF_LAT = phys_pkg::FF_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       jump_btn,
    input  logic       drop_req,
    input  logic       plat_valid,
    input  logic [8:0] plat_y,
    input  logic [8:0] ff_y,
    input  logic [8:0] ff_v,
    output logic [8:0] ff_y_init,
    output logic [8:0] ff_v_init,
    output logic [8:0] y_pos,
    output logic [8:0] v_cur,
    output logic       airborne,
    output logic       landed
);

    import phys_pkg::*;

    localparam logic [1:0] LAT_INIT = 2'(FF_LAT);

    state_t     state_q;
    height_t    y_q;
    vel_t       v_q;
    height_t    fyi_q;
    vel_t       fvi_q;
    logic [1:0] lat_q;
    logic       landed_q;
    logic       air_q;
    logic       drop_q;
    logic       drop_d;

    logic       w_pend;
    logic       w_launch;
    logic       w_drop_seen;
    logic       w_floor;
    logic       w_plat;
    logic       w_ceil;

    btn_edge u_btn_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (jump_btn),
        .clr_i  (w_launch | air_q),
        .pend_o (w_pend)
    );

    assign w_launch    = (state_q == GROUND) & frame_tick & w_pend;
    assign w_drop_seen = drop_q | drop_req;
    // A drop only matters while grounded; the latch is re-armed after every tick.
    assign drop_d      = (frame_tick | air_q) ? 1'b0 : w_drop_seen;

    assign w_floor = ff_y[8] | ((ff_y == 9'd0) & ff_v[8]);
    assign w_plat  = plat_valid & ff_v[8] & (y_q >= plat_y) & (ff_y <= plat_y);
    assign w_ceil  = ff_y > Y_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GROUND;
            y_q      <= '0;
            v_q      <= '0;
            fyi_q    <= '0;
            fvi_q    <= '0;
            lat_q    <= '0;
            landed_q <= 1'b0;
            air_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            drop_q   <= drop_d;
            case (state_q)
                GROUND: begin
                    if (frame_tick && w_pend) begin
                        v_q     <= JUMP_V;
                        state_q <= ISSUE;
                        air_q   <= 1'b1;
                    end else if (frame_tick && w_drop_seen) begin
                        v_q     <= '0;
                        state_q <= ISSUE;
                        air_q   <= 1'b1;
                    end
                end
                AIR: begin
                    if (frame_tick) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    fyi_q   <= y_q;
                    fvi_q   <= v_q;
                    lat_q   <= LAT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (lat_q != 2'd0) begin
                        lat_q <= lat_q - 2'd1;
                    end else if (w_floor) begin
                        y_q      <= '0;
                        v_q      <= '0;
                        landed_q <= 1'b1;
                        air_q    <= 1'b0;
                        state_q  <= GROUND;
                    end else if (w_plat) begin
                        y_q      <= plat_y;
                        v_q      <= '0;
                        landed_q <= 1'b1;
                        air_q    <= 1'b0;
                        state_q  <= GROUND;
                    end else if (w_ceil) begin
                        y_q     <= Y_MAX;
                        v_q     <= '0;
                        state_q <= AIR;
                    end else begin
                        y_q     <= ff_y;
                        v_q     <= ff_v;
                        state_q <= AIR;
                    end
                end
                default: state_q <= GROUND;
            endcase
        end
    end

    assign ff_y_init = fyi_q;
    assign ff_v_init = fvi_q;
    assign y_pos     = y_q;
    assign v_cur     = v_q;
    assign airborne  = air_q;
    assign landed    = landed_q;

endmodule

`default_nettype wire

// File: tb/tb_jump_ctrl.sv
// ============================================================================
// Module  : tb_jump_ctrl
// Purpose : Three jump_ctrl variants (nominal, high launch, long step latency)
//           run against a step-level model driven by directed and random stimulus.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_jump_ctrl;

    localparam int         N    = 3;
    localparam logic [8:0] YMAX = 9'd240;
    localparam logic [8:0] P_JV  [N] = '{9'd40, 9'd250, 9'd40};
    localparam int         P_LAT [N] = '{1, 1, 3};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       btn   = 1'b0;
    logic       drop  = 1'b0;
    logic       pv    = 1'b0;
    logic [8:0] py    = 9'd0;

    always #5 clk = ~clk;

    logic [8:0] d_fy [N];
    logic [8:0] d_fv [N];
    logic [8:0] d_fyi[N];
    logic [8:0] d_fvi[N];
    logic [8:0] d_y  [N];
    logic [8:0] d_v  [N];
    logic       d_air [N];
    logic       d_land[N];
    logic [8:0] st_y [N][3];
    logic [8:0] st_v [N][3];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            jump_ctrl #(
                .JUMP_V (P_JV[gi]),
                .Y_MAX  (YMAX),
                .FF_LAT (P_LAT[gi])
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .frame_tick (tick),
                .jump_btn   (btn),
                .drop_req   (drop),
                .plat_valid (pv),
                .plat_y     (py),
                .ff_y       (d_fy[gi]),
                .ff_v       (d_fv[gi]),
                .ff_y_init  (d_fyi[gi]),
                .ff_v_init  (d_fvi[gi]),
                .y_pos      (d_y[gi]),
                .v_cur      (d_v[gi]),
                .airborne   (d_air[gi]),
                .landed     (d_land[gi])
            );
            assign d_fy[gi] = st_y[gi][P_LAT[gi]-1];
            assign d_fv[gi] = st_v[gi][P_LAT[gi]-1];
        end
    endgenerate

    // Free-fall step stage: y' = y + v - 7, v' = v - 14, pipelined; never reset.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            st_y[k][0] <= d_fyi[k] + d_fvi[k] - 9'd7;
            st_v[k][0] <= d_fvi[k] - 9'd14;
            for (int j = 1; j < 3; j++) begin
                st_y[k][j] <= st_y[k][j-1];
                st_v[k][j] <= st_v[k][j-1];
            end
        end
    end

    // Step-level reference: ph = -1 grounded, 0 airborne idle, >0 edges until capture.
    logic [8:0] m_y[N], m_v[N], m_fyi[N], m_fvi[N], m_ny[N], m_nv[N];
    int         m_ph[N];
    bit         m_land[N], m_pend[N], m_ds[N];
    bit         b1, b2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1 <= 1'b0;
            b2 <= 1'b0;
            for (int k = 0; k < N; k++) begin
                m_y[k] <= 0; m_v[k] <= 0; m_fyi[k] <= 0; m_fvi[k] <= 0;
                m_ny[k] <= 0; m_nv[k] <= 0; m_ph[k] <= -1;
                m_land[k] <= 0; m_pend[k] <= 0; m_ds[k] <= 0;
            end
        end else begin
            b1 <= btn;
            b2 <= b1;
            for (int k = 0; k < N; k++) begin
                automatic bit air    = (m_ph[k] != -1);
                automatic bit rise   = b1 && !b2;
                automatic bit seen   = m_ds[k] || drop;
                automatic bit launch = !air && tick && m_pend[k];
                automatic bit go     = !air && tick && (m_pend[k] || seen);
                m_land[k] <= 1'b0;
                m_pend[k] <= (launch || air) ? 1'b0 : (rise ? 1'b1 : m_pend[k]);
                m_ds[k]   <= (tick || air) ? 1'b0 : seen;
                if (go) begin
                    m_v[k]  <= m_pend[k] ? P_JV[k] : 9'd0;
                    m_ph[k] <= P_LAT[k] + 2;
                end else if (m_ph[k] == 0 && tick) begin
                    m_ph[k] <= P_LAT[k] + 2;
                end else if (m_ph[k] > 0) begin
                    if (m_ph[k] == P_LAT[k] + 2) begin
                        m_fyi[k] <= m_y[k];
                        m_fvi[k] <= m_v[k];
                        m_ny[k]  <= m_y[k] + m_v[k] - 9'd7;
                        m_nv[k]  <= m_v[k] - 9'd14;
                    end
                    if (m_ph[k] == 1) begin
                        if (m_ny[k][8] || (m_ny[k] == 0 && m_nv[k][8])) begin
                            m_y[k] <= 0; m_v[k] <= 0; m_land[k] <= 1; m_ph[k] <= -1;
                        end else if (pv && m_nv[k][8] && m_y[k] >= py && m_ny[k] <= py) begin
                            m_y[k] <= py; m_v[k] <= 0; m_land[k] <= 1; m_ph[k] <= -1;
                        end else if (m_ny[k] > YMAX) begin
                            m_y[k] <= YMAX; m_v[k] <= 0; m_ph[k] <= 0;
                        end else begin
                            m_y[k] <= m_ny[k]; m_v[k] <= m_nv[k]; m_ph[k] <= 0;
                        end
                    end else begin
                        m_ph[k] <= m_ph[k] - 1;
                    end
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit land_seen[N];

    task automatic chk(input string name, input int k, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < N; k++) if (d_land[k]) land_seen[k] = 1'b1;
    endtask

    task automatic press();
        step(); btn = 1'b1;
        repeat (3) step();
        btn = 1'b0;
        step();
    endtask

    task automatic do_tick();
        step(); tick = 1'b1;
        step(); tick = 1'b0;
        repeat (9) step();
    endtask

    task automatic pulse_drop();
        step(); drop = 1'b1;
        step(); drop = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        for (int k = 0; k < N; k++) begin
            chk({name, "_y"}, k, d_y[k], 9'd0);
            chk({name, "_v"}, k, d_v[k], 9'd0);
            chk({name, "_fyi"}, k, d_fyi[k], 9'd0);
            chk({name, "_fvi"}, k, d_fvi[k], 9'd0);
            chk({name, "_air"}, k, d_air[k], 9'd0);
            chk({name, "_land"}, k, d_land[k], 9'd0);
        end
    endtask

    task automatic settle_all(input string name);
        int guard = 0;
        while ((d_air[0] || d_air[1] || d_air[2]) && guard < 25) begin
            do_tick();
            guard++;
        end
        chk(name, 0, guard < 25, 9'd1);
    endtask

    logic [8:0] ey [6] = '{9'd33, 9'd52, 9'd57, 9'd48, 9'd25, 9'd0};
    logic [8:0] ev [6] = '{9'd26, 9'd12, 9'h1FE, 9'h1F0, 9'h1E2, 9'd0};

    initial begin
        fork
            begin : g_cmp
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        for (int k = 0; k < N; k++) begin
                            chk("y_pos", k, d_y[k], m_y[k]);
                            chk("v_cur", k, d_v[k], m_v[k]);
                            chk("ff_y_init", k, d_fyi[k], m_fyi[k]);
                            chk("ff_v_init", k, d_fvi[k], m_fvi[k]);
                            chk("airborne", k, d_air[k], m_ph[k] != -1);
                            chk("landed", k, d_land[k], m_land[k]);
                        end
                    end
                end
            end
            begin : g_stim
                repeat (3) step();
                chk_zero("reset");
                rst_n = 1'b1;
                repeat (3) step();

                // Jump arc; instance 1 hits the ceiling, instance 2 runs the same arc slower.
                for (int k = 0; k < N; k++) land_seen[k] = 1'b0;
                press();
                for (int i = 0; i < 6; i++) begin
                    do_tick();
                    if (i == 0) begin
                        chk("arc_fvi_first", 0, d_fvi[0], 9'd40);
                        chk("ceil_y", 1, d_y[1], 9'd240);
                        chk("ceil_v", 1, d_v[1], 9'd0);
                        chk("ceil_air", 1, d_air[1], 9'd1);
                    end
                    chk("arc_model_y", 0, m_y[0], ey[i]);
                    chk("arc_model_v", 0, m_v[0], ev[i]);
                    chk("arc_y", 0, d_y[0], ey[i]);
                    chk("arc_v", 0, d_v[0], ev[i]);
                    chk("arc_lat3_y", 2, d_y[2], ey[i]);
                end
                chk("arc_landed", 0, land_seen[0], 9'd1);
                chk("arc_ground", 0, d_air[0], 9'd0);

                // Platform landing at 50.
                for (int k = 0; k < N; k++) land_seen[k] = 1'b0;
                pv = 1'b1; py = 9'd50;
                press();
                repeat (4) do_tick();
                chk("plat_y", 0, d_y[0], 9'd50);
                chk("plat_v", 0, d_v[0], 9'd0);
                chk("plat_air", 0, d_air[0], 9'd0);
                chk("plat_landed", 0, land_seen[0], 9'd1);
                chk("plat_lat3_y", 2, d_y[2], 9'd50);

                // Walk-off drop from the platform.
                pv = 1'b0;
                pulse_drop();
                do_tick();
                chk("drop_fvi", 0, d_fvi[0], 9'd0);
                chk("drop_y", 0, d_y[0], 9'd43);
                chk("drop_v", 0, d_v[0], 9'h1F2);
                settle_all("drop_settle");

                // Jump and drop on the same tick: jump wins.
                press();
                pulse_drop();
                do_tick();
                chk("jd_fvi", 0, d_fvi[0], 9'd40);

                // Jump while airborne, plus a tick landing inside the step.
                press();
                step(); tick = 1'b1; step(); tick = 1'b0;
                step(); step(); tick = 1'b1; step(); tick = 1'b0;
                repeat (8) step();
                settle_all("air_settle");
                repeat (3) do_tick();
                for (int k = 0; k < N; k++) chk("no_relaunch", k, d_air[k], 9'd0);

                // Reset asserted while instance 0 waits on the step stage.
                press();
                step(); tick = 1'b1; step(); tick = 1'b0; step();
                #2 rst_n = 1'b0;
                #1 chk_zero("midrst");
                repeat (3) step();
                rst_n = 1'b1;
                repeat (3) do_tick();
                for (int k = 0; k < N; k++) begin
                    chk("post_rst_air", k, d_air[k], 9'd0);
                    chk("post_rst_y", k, d_y[k], 9'd0);
                end

                // Random traffic against the model.
                for (int c = 0; c < 4000; c++) begin
                    step();
                    tick = ($urandom_range(0, 11) == 0);
                    drop = ($urandom_range(0, 40) == 0);
                    if ($urandom_range(0, 30) == 0) btn = ~btn;
                    if ($urandom_range(0, 200) == 0) begin
                        pv = 1'($urandom_range(0, 1));
                        py = 9'($urandom_range(0, 200));
                    end
                end
                tick = 1'b0; drop = 1'b0;
                repeat (4) step();
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
